instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 Parameter DEPTH SHALL default to 512 and give the instruction memory depth in 32-bit words.
REQ-003 Parameter AW SHALL default to 32 and give the write-address width, matching PC width.
REQ-004 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit: begins a load session when sampled high in IDLE.
REQ-007 Port len SHALL be an input, 10 bits: number of words to load, latched on start.
REQ-008 Port byte_in SHALL be an input, 8 bits: instruction byte stream.
REQ-009 Port byte_valid SHALL be an input, 1 bit: byte_in holds a valid byte.
REQ-010 Port byte_ready SHALL be an output, 1 bit: the loader accepts a byte this cycle.
REQ-011 Port wr_en SHALL be an output, 1 bit: instruction memory write strobe.
REQ-012 Port wr_addr SHALL be an output, AW bits: word index written, as used for PC indexing.
REQ-013 Port wr_data SHALL be an output, 32 bits: assembled instruction word.
REQ-014 Port busy SHALL be an output, 1 bit: a session is in progress.
REQ-015 Port cpu_hold SHALL be an output, 1 bit: stalls the fetch stage while the memory is written.
REQ-016 Port done SHALL be an output, 1 bit: one-cycle pulse at session end.
REQ-017 Port checksum SHALL be an output, 32 bits: running checksum (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-019 IDLE->LOAD SHALL occur on start=1 with len!=0; the block latches words_left=min(len,DEPTH) and clears the address to 0.
REQ-020 IDLE->DONE SHALL occur on start=1 with len=0; no write is issued.
REQ-021 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid && byte_ready.
REQ-022 Bytes SHALL be big-endian: the first accepted byte goes to wr_data[31:24] and the fourth to [7:0].
REQ-023 Acceptance of the 4th byte SHALL move LOAD->WRITE; the byte counter wraps 3->0.
REQ-024 In WRITE, wr_en SHALL be 1 for exactly one cycle with stable wr_addr and wr_data, and byte_ready SHALL be 0.
REQ-025 After WRITE, wr_addr SHALL increment by 1 and words_left decrement by 1; the FSM goes to DONE if words_left reaches 0, else back to LOAD.
REQ-026 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-027 busy and cpu_hold SHALL be 1 in LOAD and WRITE and 0 in IDLE and DONE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 byte_valid SHALL be ignored outside LOAD, and gaps in byte_valid SHALL stall assembly without loss.
REQ-030 A len value above DEPTH SHALL be clamped to DEPTH, so wr_addr never exceeds DEPTH-1.

Reset
REQ-031 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and clear the byte counter, address, words_left and checksum.
REQ-032 During reset, byte_ready, wr_en, busy, cpu_hold and done SHALL all be 0, and wr_data and wr_addr SHALL be 0.
REQ-033 Reset mid-session SHALL discard any partially assembled word and SHALL issue no write.

Configuration
REQ-034 With INSTR_LOADER_CHECKSUM_EN defined, checksum SHALL accumulate the modulo-2^32 sum of each written word, updated in the WRITE cycle and cleared on session start.
REQ-035 Without INSTR_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and the block SHALL contain no accumulator logic.

Verification
REQ-036 Load 1 word: rst_n low 2 cycles; start with len=1; send bytes 0x20,0x08,0x00,0x05 -> one write of wr_addr=0, wr_data=0x20080005, then done pulse; busy=0 afterwards.
REQ-037 Load 3 words with byte_valid toggled every other cycle -> writes to addresses 0, 1 and 2 in order, each wr_en one cycle wide, no bytes lost.
REQ-038 start with len=0 -> done pulses within 2 cycles, wr_en never asserted, cpu_hold stays 0.
REQ-039 start with len=600 -> exactly 512 writes, last wr_addr=511, then done.
REQ-040 Reset after 2 of 4 bytes, then a fresh session with len=1 and bytes 0xAABBCCDD -> no write before reset; the single write is 0xAABBCCDD at address 0.
REQ-041 With INSTR_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 at done; without the macro, checksum=0 throughout.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Assembles a big-endian byte stream into 32-bit instruction words and writes
//   them into instruction memory, holding the CPU fetch stage while loading.
//
//   Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//     defined   -> checksum is the mod-2^32 sum of every word written this session
//     undefined -> checksum is tied to 0, no accumulator is built
//
//   Ports
//     clk, rst_n         rising-edge clock, synchronous active-low reset
//     start, len         begin a session of len words (sampled in IDLE only)
//     byte_in/valid      instruction byte stream; byte_ready marks acceptance
//     wr_en/addr/data    one-cycle instruction memory write strobe, word index, word
//     busy, cpu_hold     high while a session is loading or writing
//     done               one-cycle pulse at session end
//     checksum           running checksum (see macro above)
module instr_mem_loader #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [9:0]    len,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic [31:0]   checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [9:0]    left_q, left_d;
  logic [31:0]   data_q, data_d;
  logic [9:0]    len_clamped;

  // Requests larger than the memory are clamped so the index stays in range.
  always_comb begin
    len_clamped = len;
    if (32'(len) > DEPTH) begin
      len_clamped = 10'(DEPTH);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    left_d  = left_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == 10'd0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            left_d  = len_clamped;
            addr_d  = '0;
            cnt_d   = 2'd0;
          end
        end
      end
      LOAD: begin
        if (byte_valid) begin
          // Shift left so the first byte ends up in [31:24].
          data_d = {data_q[23:0], byte_in};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        left_d = left_q - 10'd1;
        if (left_q == 10'd1) begin
          // Last word: leave the address on it so it never reaches DEPTH.
          state_d = DONE;
        end else begin
          state_d = LOAD;
          addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      left_q  <= 10'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    byte_ready = (state_q == LOAD);
    wr_en      = (state_q == WRITE);
    busy       = (state_q == LOAD) || (state_q == WRITE);
    cpu_hold   = busy;
    done       = (state_q == DONE);
    wr_addr    = addr_q;
    wr_data    = data_q;
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= 32'd0;
    end else if ((state_q == IDLE) && start) begin
      sum_q <= 32'd0;
    end else if (state_q == WRITE) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed sessions checked against a
// queue-based model of the writes each session must produce.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    len = 10'd0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: the ordered list of writes the current session must produce.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] model_sum = 32'd0;
  int          wr_count = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;
  logic [31:0] done_checksum = 32'd0;
  bit          hold_seen = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_done = 1'b0;

  // Compare process: checks every cycle with reset released.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      check32("busy_eq_cpu_hold", 32'(cpu_hold), 32'(busy));
      if (cpu_hold) hold_seen = 1'b1;
      if (wr_en) begin
        check32("ready_low_in_write", 32'(byte_ready), 32'd0);
        check32("wr_en_one_cycle", 32'(prev_wr), 32'd0);
        check32("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check32("wr_addr", wr_addr, e.addr);
          check32("wr_data", wr_data, e.data);
        end
        wr_count++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (done) begin
        check32("busy_low_at_done", 32'(busy), 32'd0);
        check32("done_one_cycle", 32'(prev_done), 32'd0);
        done_checksum = checksum;
`ifdef INSTR_LOADER_CHECKSUM_EN
        check32("checksum_at_done", checksum, model_sum);
`endif
      end
`ifndef INSTR_LOADER_CHECKSUM_EN
      check32("checksum_zero", checksum, 32'd0);
`endif
    end
    prev_wr   = wr_en;
    prev_done = done;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    cyc(n);
    check32("rst_byte_ready", 32'(byte_ready), 32'd0);
    check32("rst_wr_en", 32'(wr_en), 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_wr_data", wr_data, 32'd0);
    check32("rst_wr_addr", wr_addr, 32'd0);
    check32("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic start_session(input int l);
    len   = 10'(l);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Offers one byte until accepted; optional idle cycle afterwards.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    int t  = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      t++;
    end
    byte_valid = 1'b0;
    byte_in    = 8'h5A;
    if (!ok) check32("byte_accept_timeout", 32'(ok), 32'd1);
    if (gap) cyc(1);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    int t    = 0;
    while (!seen && t < limit) begin
      @(negedge clk);
      seen = done;
      t++;
    end
    check32("done_within_limit", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Runs a full session: the model lists min(len, DEPTH) writes at 0,1,2...
  task automatic run_session(input int l, input logic [31:0] words[$], input bit gap);
    int n;
    logic [31:0] w;
    n = (l > int'(DEPTH)) ? int'(DEPTH) : l;
    model_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: 32'(i), data: words[i]});
      model_sum = model_sum + words[i];
    end
    start_session(l);
    // With gaps, also hold start high mid-session; it must be ignored.
    if (gap) begin
      start = 1'b1;
      len   = 10'd0;
    end
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    end
    start = 1'b0;
    wait_done(20);
  endtask

  initial begin
    logic [31:0] ws[$];
    int          c0;

    // Reset held for 2 cycles, then a single word.
    do_reset(2);
    ws = '{32'h20080005};
    run_session(1, ws, 1'b0);
    check32("one_word_count", 32'(wr_count), 32'd1);
    check32("one_word_addr", last_addr, 32'd0);
    check32("one_word_data", last_data, 32'h20080005);
    check32("one_word_busy_after", 32'(busy), 32'd0);

    // Three words, byte_valid every other cycle.
    c0 = wr_count;
    ws = '{32'h11223344, 32'hDEADBEEF, 32'h0000A5C3};
    run_session(3, ws, 1'b1);
    check32("three_word_count", 32'(wr_count - c0), 32'd3);
    check32("three_word_last_addr", last_addr, 32'd2);
    check32("three_word_last_data", last_data, 32'h0000A5C3);

    // Zero-length session: done only, no writes, no hold.
    c0        = wr_count;
    hold_seen = 1'b0;
    model_sum = 32'd0;
    start_session(0);
    wait_done(2);
    check32("len0_no_write", 32'(wr_count - c0), 32'd0);
    check32("len0_no_hold", 32'(hold_seen), 32'd0);

    // Checksum wraps modulo 2^32.
    ws = '{32'hFFFFFFFF, 32'h00000002};
    run_session(2, ws, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check32("checksum_wrap", done_checksum, 32'h00000001);
`else
    check32("checksum_off", done_checksum, 32'd0);
`endif

    // Oversized request clamps to DEPTH words.
    c0 = wr_count;
    ws = {};
    for (int i = 0; i < int'(DEPTH); i++) ws.push_back((32'(i) * 32'h01010101) ^ 32'hA5000000);
    run_session(600, ws, 1'b0);
    check32("clamp_count", 32'(wr_count - c0), 32'd512);
    check32("clamp_last_addr", last_addr, 32'd511);
    check32("clamp_busy_after", 32'(busy), 32'd0);

    // Reset after two bytes discards the partial word.
    c0 = wr_count;
    start_session(1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    do_reset(2);
    check32("midreset_no_write", 32'(wr_count - c0), 32'd0);
    ws = '{32'hAABBCCDD};
    run_session(1, ws, 1'b0);
    check32("after_reset_count", 32'(wr_count - c0), 32'd1);
    check32("after_reset_addr", last_addr, 32'd0);
    check32("after_reset_data", last_data, 32'hAABBCCDD);

    check32("all_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
